regm_mp: RTL and testbench

Parametrised multi-port register file: the successor to the dual-issue register memory. It provides NR combinational read ports and NW write ports, with same-cycle write-to-read bypass across all write ports and a deterministic priority rule for write collisions. A per-register outstanding-write scoreboard gives each read port a ready flag. It sits between the issue/decode stage (reads, reservations) and the writeback stage (writes) of the multi-issue MIPS pipeline.

---
 rtl/regm_mp.sv | 116 +++++++++++
 tb/tb_regm_mp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regm_mp.sv
// Multi-port register file with write-to-read bypass, youngest-port-wins write
// priority and a per-register outstanding-write scoreboard that drives read readiness.
module regm_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NR       = 4,
  parameter int NW       = 2,
  parameter int CW       = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  output logic [NR-1:0]    rready,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  input  logic [NW-1:0]    rsv,
  input  logic [NW*AW-1:0] rsv_addr,
  output logic             sb_err
);

  localparam int CMAX = (1 << CW) - 1;
  localparam bit ZR   = (ZERO_REG != 0);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [CW-1:0] cnt_q [DEPTH];
  logic [CW-1:0] cnt_d [DEPTH];
  logic          sb_err_q, sb_err_d;

  // Ports are applied in ascending order so the highest-indexed (youngest) write wins.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) mem_d[r] = mem_q[r];
    for (int w = 0; w < NW; w++) begin
      if (we[w] && !(ZR && waddr[w*AW +: AW] == '0))
        mem_d[waddr[w*AW +: AW]] = wdata[w*DW +: DW];
    end
  end

  always_comb begin
    int sum;
    sum      = 0;
    sb_err_d = sb_err_q;
    for (int r = 0; r < DEPTH; r++) begin
      sum = int'(cnt_q[r]);
      for (int w = 0; w < NW; w++) begin
        if (rsv[w] && rsv_addr[w*AW +: AW] == AW'(r)) sum = sum + 1;
        if (we[w] && waddr[w*AW +: AW] == AW'(r))     sum = sum - 1;
      end
      cnt_d[r] = cnt_q[r];
      if (!(ZR && r == 0)) begin
        if (sum > CMAX) begin
          cnt_d[r] = CW'(CMAX);
          sb_err_d = 1'b1;
        end else if (sum < 0) begin
          cnt_d[r] = '0;
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = CW'(sum);
        end
      end
    end
  end

  // A read is ready if nothing is pending, or every pending write lands this cycle.
  always_comb begin
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    int            pend;
    a      = '0;
    v      = '0;
    pend   = 0;
    rdata  = '0;
    rready = '0;
    for (int i = 0; i < NR; i++) begin
      a    = raddr[i*AW +: AW];
      v    = mem_q[a];
      pend = 0;
      for (int w = 0; w < NW; w++) begin
        if (we[w] && waddr[w*AW +: AW] == a) begin
          v    = wdata[w*DW +: DW];
          pend = pend + 1;
        end
      end
      if (ZR && a == '0) begin
        rdata[i*DW +: DW] = '0;
        rready[i]         = 1'b1;
      end else begin
        rdata[i*DW +: DW] = v;
        rready[i]         = (cnt_q[a] == '0) || (int'(cnt_q[a]) - pend == 0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
        cnt_q[r] <= cnt_d[r];
      end
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regm_mp.sv
// Scoreboard bench for regm_mp: a driver pushes model predictions per cycle,
// a monitor pops and compares them against the combinational outputs.
module tb_regm_mp;

  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int AW = 5;
  localparam int CMAX = 3;

  logic             clk;
  logic             reset;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rready;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NW-1:0]    rsv;
  logic [NW*AW-1:0] rsv_addr;
  logic             sb_err;

  regm_mp #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(NW), .CW(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rready(rready),
    .we(we), .waddr(waddr), .wdata(wdata), .rsv(rsv), .rsv_addr(rsv_addr),
    .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rdy;
    logic             err;
  } exp_t;

  exp_t expQ[$];
  event issued;
  int   total = 0;
  int   bad = 0;

  logic [DW-1:0] memM [DEPTH];
  int            cntM [DEPTH];
  bit            errM;

  function automatic exp_t predict();
    exp_t e;
    e.rd  = '0;
    e.rdy = '0;
    e.err = errM;
    for (int i = 0; i < NR; i++) begin
      int a;
      int nHit;
      logic [DW-1:0] d;
      a = int'(raddr[i*AW +: AW]);
      if (a == 0) begin
        e.rd[i*DW +: DW] = '0;
        e.rdy[i] = 1'b1;
      end else begin
        d = memM[a];
        nHit = 0;
        for (int w = NW - 1; w >= 0; w--) begin
          if (we[w] && int'(waddr[w*AW +: AW]) == a) begin
            if (nHit == 0) d = wdata[w*DW +: DW];
            nHit++;
          end
        end
        e.rd[i*DW +: DW] = d;
        e.rdy[i] = (cntM[a] == 0) || (cntM[a] - nHit == 0);
      end
    end
    return e;
  endfunction

  task automatic updateModel();
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        memM[r] = '0;
        cntM[r] = 0;
      end
      errM = 1'b0;
    end else begin
      int nc [DEPTH];
      for (int r = 0; r < DEPTH; r++) nc[r] = cntM[r];
      for (int w = 0; w < NW; w++) begin
        if (rsv[w]) nc[int'(rsv_addr[w*AW +: AW])]++;
        if (we[w]) begin
          nc[int'(waddr[w*AW +: AW])]--;
          if (waddr[w*AW +: AW] != '0) memM[int'(waddr[w*AW +: AW])] = wdata[w*DW +: DW];
        end
      end
      for (int r = 1; r < DEPTH; r++) begin
        if (nc[r] > CMAX) begin
          nc[r] = CMAX;
          errM = 1'b1;
        end else if (nc[r] < 0) begin
          nc[r] = 0;
          errM = 1'b1;
        end
        cntM[r] = nc[r];
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [NR*AW-1:0] ra,
                               input logic [NW-1:0] w, input logic [NW*AW-1:0] wa,
                               input logic [NW*DW-1:0] wd, input logic [NW-1:0] rs,
                               input logic [NW*AW-1:0] rsa);
    @(negedge clk);
    reset    = rst;
    raddr    = ra;
    we       = w;
    waddr    = wa;
    wdata    = wd;
    rsv      = rs;
    rsv_addr = rsa;
    expQ.push_back(predict());
    -> issued;
    @(posedge clk);
    updateModel();
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every issued cycle presents a result.
  initial begin
    exp_t e;
    forever begin
      @(issued);
      #2;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL queue: got empty expected entry");
      end else begin
        e = expQ.pop_front();
        for (int i = 0; i < NR; i++) begin
          checkOutput($sformatf("rdata%0d", i), rdata[i*DW +: DW], e.rd[i*DW +: DW]);
          checkOutput($sformatf("rready%0d", i), {31'b0, rready[i]}, {31'b0, e.rdy[i]});
        end
        checkOutput("sb_err", {31'b0, sb_err}, {31'b0, e.err});
      end
    end
  end

  localparam logic [NR*AW-1:0] RD0123 = {5'd3, 5'd2, 5'd1, 5'd0};

  initial begin
    reset = 1'b1; raddr = '0; we = '0; waddr = '0; wdata = '0; rsv = '0; rsv_addr = '0;
    for (int r = 0; r < DEPTH; r++) begin
      memM[r] = '0;
      cntM[r] = 0;
    end
    errM = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, then idle reads of r0..r3.
    applyStimulus(1'b1, RD0123, 2'b11, {5'd2, 5'd1}, {32'h5, 32'h6}, 2'b11, {5'd1, 5'd2});
    applyStimulus(1'b0, RD0123, '0, '0, '0, '0, '0);
    // Bypass then stored read of r5.
    applyStimulus(1'b0, {15'd0, 5'd5}, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, '0, '0);
    applyStimulus(1'b0, {15'd0, 5'd5}, '0, '0, '0, '0, '0);
    // Collision on r7.
    applyStimulus(1'b0, {5'd7, 5'd0, 5'd0, 5'd7}, 2'b11, {5'd7, 5'd7}, {32'h2222, 32'h1111}, '0, '0);
    applyStimulus(1'b0, {5'd7, 5'd0, 5'd0, 5'd7}, '0, '0, '0, '0, '0);
    // Scoreboard on r9.
    applyStimulus(1'b0, {15'd0, 5'd9}, '0, '0, '0, 2'b01, {5'd0, 5'd9});
    applyStimulus(1'b0, {15'd0, 5'd9}, '0, '0, '0, '0, '0);
    applyStimulus(1'b0, {15'd0, 5'd9}, 2'b01, {5'd0, 5'd9}, {32'h0, 32'hAB}, '0, '0);
    applyStimulus(1'b0, {15'd0, 5'd9}, '0, '0, '0, 2'b11, {5'd9, 5'd9});
    applyStimulus(1'b0, {15'd0, 5'd9}, 2'b10, {5'd9, 5'd0}, {32'h77, 32'h0}, '0, '0);
    applyStimulus(1'b0, {15'd0, 5'd9}, '0, '0, '0, '0, '0);
    // Overflow on r3, then underflow on unreserved r4.
    applyStimulus(1'b1, '0, '0, '0, '0, '0, '0);
    applyStimulus(1'b0, {5'd4, 5'd3, 10'd0}, '0, '0, '0, 2'b11, {5'd3, 5'd3});
    applyStimulus(1'b0, {5'd4, 5'd3, 10'd0}, '0, '0, '0, 2'b11, {5'd3, 5'd3});
    applyStimulus(1'b0, {5'd4, 5'd3, 10'd0}, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h44}, '0, '0);
    applyStimulus(1'b0, {5'd4, 5'd3, 10'd0}, '0, '0, '0, '0, '0);
    // Register 0 ignores writes and reservations.
    applyStimulus(1'b1, '0, '0, '0, '0, '0, '0);
    applyStimulus(1'b0, '0, 2'b01, '0, {32'h0, 32'h55}, 2'b01, '0);
    applyStimulus(1'b0, '0, '0, '0, '0, '0, '0);

    // Randomized traffic over a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic [NR*AW-1:0] ra;
      logic [NW*AW-1:0] wa, rsa;
      logic [NW*DW-1:0] wd;
      logic [NW-1:0]    w, rs;
      for (int i = 0; i < NR; i++) ra[i*AW +: AW] = AW'($urandom_range(0, 7));
      for (int k = 0; k < NW; k++) begin
        wa[k*AW +: AW]  = AW'($urandom_range(0, 7));
        rsa[k*AW +: AW] = AW'($urandom_range(0, 7));
        wd[k*DW +: DW]  = $urandom;
        w[k]  = ($urandom_range(0, 99) < 35);
        rs[k] = ($urandom_range(0, 99) < 35);
      end
      applyStimulus(($urandom_range(0, 39) == 0), ra, w, wa, wd, rs, rsa);
    end

    @(negedge clk);
    #3;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d entries expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
